i2c_slave: RTL and testbench

I2C target (slave) endpoint: the responder counterpart to the team's I2C master on the same two-wire bus. Oversamples SCL/SDA on the system clock, detects START/STOP, matches a fixed 7-bit address, then shifts write bytes out to a local byte interface and serves read bytes from it. Drives the bus open-drain only, releasing to `z` for a `1`. An optional build feature lets it stretch SCL while waiting for read data.

---
 rtl/i2c_slave.sv | 235 +++++++++++++++++++++++
 tb/tb_i2c_slave.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave.sv
// I2C target endpoint with a fixed 7-bit address and a local byte interface.
// SCL/SDA are oversampled on clk and driven open-drain: 0 or released (z).
// Optional build feature I2C_SLAVE_CLKSTRETCH_EN: hold SCL low while waiting
// for read data instead of sending 8'hFF on an underrun.
//
// Read-data handshake: tx_req is a one-cycle pulse on the SCL rise of the
// ACK clock. The first cycle afterwards with tx_valid=1 captures txdata
// (a single-cycle valid is enough; no ready is returned). A byte presented
// on the same cycle as the load edge (the following SCL fall) still counts.
module i2c_slave #(
    parameter logic [6:0] ADDRESS      = 7'h42,
    parameter int         SETUP_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    inout  wire        scl,
    inout  wire        sda,
    input  logic [7:0] txdata,
    input  logic       tx_valid,
    output logic       tx_req,
    output logic       tx_underrun,
    output logic [7:0] rxdata,
    output logic       rx_valid,
    output logic       rw,
    output logic       busy,
    output logic [2:0] fsm_state
);

`ifdef I2C_SLAVE_CLKSTRETCH_EN
    localparam bit STRETCH_EN = 1'b1;
`else
    localparam bit STRETCH_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ADDR      = 3'd1,
        ADDR_ACK  = 3'd2,
        RX        = 3'd3,
        RX_ACK    = 3'd4,
        TX        = 3'd5,
        TX_ACK    = 3'd6,
        WAIT_STOP = 3'd7
    } state_t;

    state_t     state;
    logic       scl_s1, scl_s2, scl_prev;
    logic       sda_s1, sda_s2, sda_prev;
    logic       sda_oe, scl_oe;
    logic [7:0] shift;
    logic [3:0] bit_cnt;
    logic       tx_wait, tx_have;
    logic [7:0] tx_buf;
    logic       stretch_wait;
    logic [3:0] setup_cnt;

    logic       scl_rise, scl_fall, start_cond, stop_cond;
    logic       load_ok;
    logic [7:0] load_byte;

    assign scl = scl_oe ? 1'b0 : 1'bz;
    assign sda = sda_oe ? 1'b0 : 1'bz;
    assign fsm_state = state;

    // Two-flop synchronizers plus one history stage for edge detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            scl_s1   <= 1'b1;
            scl_s2   <= 1'b1;
            scl_prev <= 1'b1;
            sda_s1   <= 1'b1;
            sda_s2   <= 1'b1;
            sda_prev <= 1'b1;
        end else begin
            scl_s1   <= scl;
            scl_s2   <= scl_s1;
            scl_prev <= scl_s2;
            sda_s1   <= sda;
            sda_s2   <= sda_s1;
            sda_prev <= sda_s2;
        end
    end

    assign scl_rise   = scl_s2 & ~scl_prev;
    assign scl_fall   = ~scl_s2 & scl_prev;
    // SCL must be high on both samples so an SDA change is a bus condition.
    assign start_cond = scl_s2 & scl_prev & sda_prev & ~sda_s2;
    assign stop_cond  = scl_s2 & scl_prev & ~sda_prev & sda_s2;

    // Byte to load at the TX entry edge; a same-cycle tx_valid is in time.
    assign load_ok   = tx_have | (tx_wait & tx_valid);
    assign load_byte = tx_have ? tx_buf : ((tx_wait & tx_valid) ? txdata : 8'hFF);

    // Protocol FSM: bus conditions first, then per-state SCL edge handling.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            sda_oe       <= 1'b0;
            scl_oe       <= 1'b0;
            shift        <= 8'h00;
            bit_cnt      <= 4'd0;
            rxdata       <= 8'h00;
            rx_valid     <= 1'b0;
            tx_req       <= 1'b0;
            tx_underrun  <= 1'b0;
            rw           <= 1'b0;
            busy         <= 1'b0;
            tx_wait      <= 1'b0;
            tx_have      <= 1'b0;
            tx_buf       <= 8'h00;
            stretch_wait <= 1'b0;
            setup_cnt    <= 4'd0;
        end else begin
            rx_valid    <= 1'b0;
            tx_req      <= 1'b0;
            tx_underrun <= 1'b0;

            if (tx_wait && tx_valid) begin
                tx_buf  <= txdata;
                tx_have <= 1'b1;
                tx_wait <= 1'b0;
            end

            if (start_cond || stop_cond) begin
                state        <= start_cond ? ADDR : IDLE;
                bit_cnt      <= 4'd0;
                sda_oe       <= 1'b0;
                scl_oe       <= 1'b0;
                stretch_wait <= 1'b0;
                setup_cnt    <= 4'd0;
                tx_wait      <= 1'b0;
                tx_have      <= 1'b0;
                if (stop_cond) busy <= 1'b0;
            end else begin
                case (state)
                    ADDR: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_s2};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            if (shift[7:1] == ADDRESS) begin
                                rw     <= shift[0];
                                busy   <= 1'b1;
                                sda_oe <= 1'b1;
                                state  <= ADDR_ACK;
                            end else begin
                                busy  <= 1'b0;
                                state <= WAIT_STOP;
                            end
                        end
                    end
                    ADDR_ACK, TX_ACK: begin
                        if (scl_rise) begin
                            if (state == TX_ACK && sda_s2) begin
                                busy  <= 1'b0;
                                state <= WAIT_STOP;
                            end else if (rw) begin
                                tx_req  <= 1'b1;
                                tx_wait <= 1'b1;
                                tx_have <= 1'b0;
                            end
                        end else if (scl_fall) begin
                            if (!rw) begin
                                sda_oe  <= 1'b0;
                                bit_cnt <= 4'd0;
                                state   <= RX;
                            end else if (load_ok || !STRETCH_EN) begin
                                shift       <= load_byte;
                                sda_oe      <= ~load_byte[7];
                                bit_cnt     <= 4'd1;
                                tx_have     <= 1'b0;
                                tx_wait     <= 1'b0;
                                tx_underrun <= ~load_ok;
                                state       <= TX;
                            end else begin
                                sda_oe       <= 1'b0;
                                scl_oe       <= 1'b1;
                                stretch_wait <= 1'b1;
                                state        <= TX;
                            end
                        end
                    end
                    RX: begin
                        if (scl_rise) begin
                            shift   <= {shift[6:0], sda_s2};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            rxdata   <= shift;
                            rx_valid <= 1'b1;
                            sda_oe   <= 1'b1;
                            state    <= RX_ACK;
                        end
                    end
                    RX_ACK: begin
                        if (scl_fall) begin
                            sda_oe  <= 1'b0;
                            bit_cnt <= 4'd0;
                            state   <= RX;
                        end
                    end
                    TX: begin
                        if (stretch_wait) begin
                            // SCL is held low here, so no SCL edges can arrive.
                            if (tx_valid) begin
                                shift        <= txdata;
                                sda_oe       <= ~txdata[7];
                                bit_cnt      <= 4'd1;
                                tx_wait      <= 1'b0;
                                tx_have      <= 1'b0;
                                stretch_wait <= 1'b0;
                                setup_cnt    <= 4'(SETUP_CYCLES);
                            end
                        end else if (setup_cnt != 4'd0) begin
                            setup_cnt <= setup_cnt - 4'd1;
                            if (setup_cnt == 4'd1) scl_oe <= 1'b0;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe <= 1'b0;
                                state  <= TX_ACK;
                            end else begin
                                sda_oe  <= ~shift[6];
                                shift   <= {shift[6:0], 1'b0};
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    default: begin
                        // IDLE and WAIT_STOP keep both lines released.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave.sv
// Self-checking bench for i2c_slave: bit-banged bus master, host responder
// for read data, scoreboards for written and read bytes.
module tb_i2c_slave;
    localparam int Q     = 10;
    localparam int H     = 20;
    localparam int SETUP = 4;
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_WAIT_STOP = 3'd7;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic m_scl_oe = 1'b0;
    logic m_sda_oe = 1'b0;
    wire  scl_bus;
    wire  sda_bus;
    pullup (scl_bus);
    pullup (sda_bus);
    assign scl_bus = m_scl_oe ? 1'b0 : 1'bz;
    assign sda_bus = m_sda_oe ? 1'b0 : 1'bz;

    logic [7:0] txdata = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_req, tx_underrun, rx_valid, rw, busy;
    logic [7:0] rxdata;
    logic [2:0] fsm_state;

    i2c_slave #(.ADDRESS(7'h42), .SETUP_CYCLES(SETUP)) dut (
        .clk(clk), .reset(reset), .scl(scl_bus), .sda(sda_bus),
        .txdata(txdata), .tx_valid(tx_valid), .tx_req(tx_req),
        .tx_underrun(tx_underrun), .rxdata(rxdata), .rx_valid(rx_valid),
        .rw(rw), .busy(busy), .fsm_state(fsm_state)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] rx_exp_q[$];
    logic [7:0] rd_exp_q[$];
    logic [7:0] host_q[$];
    logic host_en = 1'b0;
    int   host_delay = 3;
    logic measure = 1'b0;

    int rx_cnt = 0, req_cnt = 0, urun_cnt = 0, slave_low_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clk_wait(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Output monitor: written-byte scoreboard and event counters.
    always @(negedge clk) begin
        if (rx_valid) begin
            rx_cnt++;
            check("rx_q_nonempty", 32'(rx_exp_q.size() != 0), 1);
            if (rx_exp_q.size() != 0) check("rxdata", rxdata, rx_exp_q.pop_front());
        end
        if (tx_req) req_cnt++;
        if (tx_underrun) urun_cnt++;
        if (!reset && !m_sda_oe && sda_bus === 1'b0) slave_low_cnt++;
    end

    // Host side: answer tx_req with the next queued byte after host_delay.
    initial begin
        forever begin
            @(negedge clk);
            if (tx_req && host_en && host_q.size() != 0) begin
                logic [7:0] b;
                b = host_q.pop_front();
                rd_exp_q.push_back(b);
                repeat (host_delay) @(negedge clk);
                txdata   = b;
                tx_valid = 1'b1;
                @(negedge clk);
                tx_valid = 1'b0;
                if (measure) begin
                    int   n;
                    logic bad;
                    n = 0;
                    bad = 1'b0;
                    while (scl_bus === 1'b0 && n < 200) begin
                        if (sda_bus !== b[7]) bad = 1'b1;
                        n++;
                        @(negedge clk);
                    end
                    check("stretch_setup_cycles", n, SETUP);
                    check("stretch_sda_stable", bad, 0);
                end
            end
        end
    end

    task automatic wait_scl_high();
        int n;
        n = 0;
        while (scl_bus !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (scl_bus !== 1'b1) check("scl_high_timeout", 32'(scl_bus), 1);
    endtask

    task automatic m_start();
        m_sda_oe = 1'b0; clk_wait(Q);
        m_scl_oe = 1'b0; wait_scl_high(); clk_wait(Q);
        m_sda_oe = 1'b1; clk_wait(Q);
        m_scl_oe = 1'b1; clk_wait(Q);
    endtask

    task automatic m_stop();
        m_sda_oe = 1'b1; clk_wait(Q);
        m_scl_oe = 1'b0; wait_scl_high(); clk_wait(Q);
        m_sda_oe = 1'b0; clk_wait(Q);
    endtask

    task automatic m_bit_write(input logic b);
        m_sda_oe = ~b; clk_wait(Q);
        m_scl_oe = 1'b0; wait_scl_high(); clk_wait(H);
        m_scl_oe = 1'b1; clk_wait(Q);
    endtask

    task automatic m_bit_read(output logic b);
        m_sda_oe = 1'b0; clk_wait(Q);
        m_scl_oe = 1'b0; wait_scl_high(); clk_wait(H / 2);
        b = sda_bus;
        clk_wait(H / 2);
        m_scl_oe = 1'b1; clk_wait(Q);
    endtask

    task automatic m_write_byte(input logic [7:0] d, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) m_bit_write(d[i]);
        m_bit_read(b);
        ack = ~b;
    endtask

    task automatic m_read_byte(input logic give_ack);
        logic [7:0] d;
        logic b;
        for (int i = 7; i >= 0; i--) begin
            m_bit_read(b);
            d[i] = b;
        end
        m_bit_write(~give_ack);
        check("rd_q_nonempty", 32'(rd_exp_q.size() != 0), 1);
        if (rd_exp_q.size() != 0) check("rd_byte", d, rd_exp_q.pop_front());
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ack, b;
        logic [7:0] wr_bytes [2];
        int r0, s0, q0, u0;
        wr_bytes = '{8'hA5, 8'h3C};

        clk_wait(5);
        reset = 1'b0;
        clk_wait(5);
        check("rst_rxdata", rxdata, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_tx_req", tx_req, 0);
        check("rst_tx_underrun", tx_underrun, 0);
        check("rst_rw", rw, 0);
        check("rst_busy", busy, 0);
        check("rst_sda", sda_bus, 1);
        check("rst_scl", scl_bus, 1);
        check("rst_state", fsm_state, ST_IDLE);

        // Write 0xA5, 0x3C to the matching address.
        r0 = rx_cnt;
        m_start();
        m_write_byte(8'h84, ack);
        check("t1_addr_ack", ack, 1);
        check("t1_busy", busy, 1);
        check("t1_rw", rw, 0);
        for (int i = 0; i < 2; i++) begin
            rx_exp_q.push_back(wr_bytes[i]);
            m_write_byte(wr_bytes[i], ack);
            check("t1_data_ack", ack, 1);
        end
        m_stop();
        clk_wait(5);
        check("t1_busy_after_stop", busy, 0);
        check("t1_rx_count", rx_cnt - r0, 2);
        check("t1_rxdata_last", rxdata, 8'h3C);
        check("t1_state_idle", fsm_state, ST_IDLE);

        // Write to a different address: bus must stay untouched.
        r0 = rx_cnt;
        s0 = slave_low_cnt;
        m_start();
        m_write_byte(8'h86, ack);
        check("t2_addr_nack", ack, 0);
        check("t2_busy", busy, 0);
        check("t2_state_wait_stop", fsm_state, ST_WAIT_STOP);
        m_write_byte(8'h00, ack);
        check("t2_data_nack", ack, 0);
        check("t2_sda_never_driven", slave_low_cnt - s0, 0);
        check("t2_rx_count", rx_cnt - r0, 0);
        m_stop();
        clk_wait(5);
        check("t2_busy_after_stop", busy, 0);

        // Read two bytes, ACK then NACK.
        host_en = 1'b1;
        host_delay = 3;
        host_q.push_back(8'h5A);
        host_q.push_back(8'hC3);
        q0 = req_cnt;
        u0 = urun_cnt;
        m_start();
        m_write_byte(8'h85, ack);
        check("t3_addr_ack", ack, 1);
        check("t3_rw", rw, 1);
        m_read_byte(1'b1);
        m_read_byte(1'b0);
        clk_wait(5);
        check("t3_state_wait_stop", fsm_state, ST_WAIT_STOP);
        check("t3_busy_after_nack", busy, 0);
        check("t3_req_count", req_cnt - q0, 2);
        check("t3_underrun_count", urun_cnt - u0, 0);
        m_stop();
        host_en = 1'b0;

        // Read with no data offered in time.
        u0 = urun_cnt;
`ifdef I2C_SLAVE_CLKSTRETCH_EN
        host_en = 1'b1;
        host_delay = 100;
        measure = 1'b1;
        host_q.push_back(8'h77);
`else
        rd_exp_q.push_back(8'hFF);
`endif
        m_start();
        m_write_byte(8'h85, ack);
        check("t4_addr_ack", ack, 1);
        m_read_byte(1'b0);
        m_stop();
`ifdef I2C_SLAVE_CLKSTRETCH_EN
        check("t4_underrun_count", urun_cnt - u0, 0);
`else
        check("t4_underrun_count", urun_cnt - u0, 1);
`endif
        measure = 1'b0;
        host_en = 1'b0;
        host_delay = 3;

        // Write a byte, then repeated START into a read.
        host_en = 1'b1;
        host_q.push_back(8'h99);
        m_start();
        m_write_byte(8'h84, ack);
        check("t5_addr_ack", ack, 1);
        rx_exp_q.push_back(8'h11);
        m_write_byte(8'h11, ack);
        check("t5_data_ack", ack, 1);
        q0 = req_cnt;
        m_start();
        m_write_byte(8'h85, ack);
        check("t5_rd_addr_ack", ack, 1);
        check("t5_rw", rw, 1);
        check("t5_busy", busy, 1);
        check("t5_req_count", req_cnt - q0, 1);
        m_read_byte(1'b0);
        m_stop();

        // Reset in the middle of a read byte while SDA is driven low.
        host_q.push_back(8'h00);
        m_start();
        m_write_byte(8'h85, ack);
        check("t6_addr_ack", ack, 1);
        for (int i = 0; i < 3; i++) begin
            m_bit_read(b);
            check("t6_bit", b, 0);
        end
        check("t6_sda_driven", sda_bus, 0);
        reset = 1'b1;
        @(negedge clk);
        check("t6_sda_released", sda_bus, 1);
        check("t6_scl_low_by_master", scl_bus, 0);
        check("t6_busy", busy, 0);
        check("t6_rw", rw, 0);
        check("t6_rxdata", rxdata, 8'h00);
        check("t6_rx_valid", rx_valid, 0);
        check("t6_tx_req", tx_req, 0);
        check("t6_tx_underrun", tx_underrun, 0);
        check("t6_state", fsm_state, ST_IDLE);
        reset = 1'b0;
        host_en = 1'b0;
        rd_exp_q.delete();
        m_stop();
        clk_wait(5);
        check("t6_scl_released", scl_bus, 1);

        check("rx_q_drained", rx_exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
